// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial 4-bit subtractor tile: computes A - B - Bin one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow register,
// then holds the difference and borrow-out for HOLD_CYCLES cycles.
module tt_um_serial_subtractor #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [9:0] HOLD_LAST = 10'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic       start_q;
  logic       start_edge;
  logic [3:0] a_sr;
  logic [3:0] b_sr;
  logic       br;
  logic [1:0] bit_cnt;
  logic [3:0] res_sr;
  logic [3:0] d_q;
  logic       bout_q;
  logic [9:0] hold_cnt;

  logic       load;
  logic       shift_en;
  logic       finish;
  logic       clear;
  logic       hold_inc;
  logic       diff_bit;
  logic       br_next;
  logic       last_bit;
  logic       hold_last;
  logic       unused_pins;

  // uio_in[7:2] carry no function on this tile.
  assign unused_pins = &{1'b0, uio_in[7:2]};

  // Full-subtractor cell on the current LSBs plus the end-of-operation tests.
  assign start_edge = uio_in[0] & ~start_q;
  assign diff_bit   = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last_bit   = (bit_cnt == 2'd3);
  assign hold_last  = (hold_cnt == HOLD_LAST);

  // Next-state and datapath control; a start edge in HOLD restarts the operation.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    clear      = 1'b0;
    hold_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          finish     = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (start_edge) begin
          load       = 1'b1;
          next_state = SHIFT;
        end else if (hold_last) begin
          clear      = 1'b1;
          next_state = IDLE;
        end else begin
          hold_inc = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; ena low freezes the machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= next_state;
    end
  end

  // Previous start level for rising-edge detection, sampled every enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else if (ena) begin
      start_q <= uio_in[0];
    end
  end

  // Operand shift registers, borrow register, bit counter and partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= 4'd0;
      b_sr    <= 4'd0;
      br      <= 1'b0;
      bit_cnt <= 2'd0;
      res_sr  <= 4'd0;
    end else if (ena) begin
      if (load) begin
        a_sr    <= ui_in[7:4];
        b_sr    <= ui_in[3:0];
        br      <= uio_in[1];
        bit_cnt <= 2'd0;
        res_sr  <= 4'd0;
      end else if (shift_en) begin
        a_sr    <= {1'b0, a_sr[3:1]};
        b_sr    <= {1'b0, b_sr[3:1]};
        br      <= br_next;
        bit_cnt <= bit_cnt + 2'd1;
        res_sr  <= {diff_bit, res_sr[3:1]};
      end
    end
  end

  // Visible result and hold timer; the old result stays up across a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= 4'd0;
      bout_q   <= 1'b0;
      hold_cnt <= 10'd0;
    end else if (ena) begin
      if (finish) begin
        d_q      <= {diff_bit, res_sr[3:1]};
        bout_q   <= br_next;
        hold_cnt <= 10'd0;
      end else if (clear) begin
        d_q    <= 4'd0;
        bout_q <= 1'b0;
      end else if (hold_inc) begin
        hold_cnt <= hold_cnt + 10'd1;
      end
    end
  end

  assign uo_out  = {3'b000, bout_q, d_q};
  assign uio_out = {4'b0000, (state == HOLD), (state == SHIFT), 2'b00};
  assign uio_oe  = 8'b1111_1100;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Self-checking bench for the serial subtractor tile (HOLD_CYCLES = 8),
// comparing against plain integer subtraction.
module tb_tt_um_serial_subtractor;

  localparam int HOLD = 8;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_uo = 8'h00;

  tt_um_serial_subtractor #(.HOLD_CYCLES(HOLD)) dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation: start edge, four busy cycles, then the result.
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic bin,
                                input string tag);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    ui_in  = {a, b};
    uio_in = {6'($urandom), bin, 1'b1};
    step();
    check_output({tag, " busy"}, uio_out, 8'h04);
    check_output({tag, " old"}, uo_out, model_uo);
    uio_in[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ui_in     = 8'($urandom);
      uio_in[1] = 1'($urandom);
      step();
      check_output({tag, " busy"}, uio_out, 8'h04);
      check_output({tag, " old"}, uo_out, model_uo);
    end
    step();
    model_uo = {3'b000, (r < 0), 4'(r)};
    check_output({tag, " result"}, uo_out, model_uo);
    check_output({tag, " done"}, uio_out, 8'h08);
  endtask

  // Follow the hold window to its end; done must last exactly HOLD cycles.
  task automatic wait_hold(input string tag);
    int cnt;
    cnt = 0;
    while (uio_out[3] === 1'b1 && cnt < 40) begin
      check_output({tag, " held"}, uo_out, model_uo);
      cnt++;
      step();
    end
    checks++;
    assert (cnt == HOLD) else begin
      errors++;
      $error("[TB] FAIL %s hold_len observed=%0d expected=%0d", tag, cnt, HOLD);
    end
    model_uo = 8'h00;
    check_output({tag, " cleared"}, uo_out, 8'h00);
    check_output({tag, " idle"}, uio_out, 8'h00);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    logic [7:0] seen;

    // Reset with random inputs, checked before any clock edge.
    rst_n  = 1'b0;
    ena    = 1'($urandom);
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    #2;
    check_output("reset uo_out", uo_out, 8'h00);
    check_output("reset uio_out", uio_out, 8'h00);
    check_output("reset uio_oe", uio_oe, 8'hFC);
    @(negedge clk);
    uio_in = 8'h00;
    ena    = 1'b1;
    rst_n  = 1'b1;
    step();
    check_output("idle after reset", uio_out, 8'h00);

    // Basic operation and full hold window.
    apply_stimulus(4'd9, 4'd3, 1'b0, "basic");
    wait_hold("basic");

    // Borrow corner cases.
    apply_stimulus(4'd2, 4'd5, 1'b0, "2-5");
    wait_hold("2-5");
    apply_stimulus(4'd0, 4'd0, 1'b1, "0-0-1");
    wait_hold("0-0-1");
    apply_stimulus(4'd15, 4'd15, 1'b0, "15-15");
    wait_hold("15-15");

    // Exhaustive sweep, each operation restarting from the previous hold.
    for (int i = 0; i < 512; i++) begin
      apply_stimulus(4'(i >> 5), 4'(i >> 1), 1'(i), "sweep");
    end
    wait_hold("sweep");

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(4'($urandom), 4'($urandom), 1'($urandom), "random");
    end
    wait_hold("random");

    // Start held high for 20 cycles yields a single operation.
    busy_cnt = 0;
    done_cnt = 0;
    seen     = 8'h00;
    ui_in    = {4'd9, 4'd3};
    uio_in   = 8'h01;
    for (int k = 0; k < 20; k++) begin
      step();
      if (uio_out[2] === 1'b1) busy_cnt++;
      if (uio_out[3] === 1'b1) begin
        done_cnt++;
        seen = uo_out;
      end
    end
    checks++;
    assert (busy_cnt == 4) else begin
      errors++;
      $error("[TB] FAIL held_start busy_cycles observed=%0d expected=4", busy_cnt);
    end
    checks++;
    assert (done_cnt == HOLD) else begin
      errors++;
      $error("[TB] FAIL held_start done_cycles observed=%0d expected=%0d", done_cnt, HOLD);
    end
    check_output("held_start result", seen, 8'h06);
    uio_in = 8'h00;
    step();
    check_output("held_start idle", uio_out, 8'h00);

    // Start toggled during SHIFT is ignored.
    ui_in  = {4'd12, 4'd7};
    uio_in = 8'h01;
    step();
    check_output("toggle busy", uio_out, 8'h04);
    for (int k = 0; k < 3; k++) begin
      uio_in = {6'd0, 1'($urandom), ~uio_in[0]};
      ui_in  = 8'($urandom);
      step();
      check_output("toggle busy", uio_out, 8'h04);
    end
    uio_in = 8'h00;
    step();
    model_uo = 8'h05;
    check_output("toggle result", uo_out, model_uo);
    check_output("toggle done", uio_out, 8'h08);
    wait_hold("toggle");

    // Restart in HOLD: old result stays until the new one lands.
    apply_stimulus(4'd9, 4'd3, 1'b0, "pre_restart");
    step();
    step();
    check_output("pre_restart still done", uio_out, 8'h08);
    apply_stimulus(4'd4, 4'd7, 1'b0, "restart");
    check_output("restart value", uo_out, 8'h1D);
    wait_hold("restart");

    // Asynchronous reset in the middle of SHIFT, with a result still shown.
    apply_stimulus(4'd14, 4'd1, 1'b0, "pre_reset");
    ui_in  = {4'd9, 4'd3};
    uio_in = 8'h01;
    step();
    uio_in = 8'h00;
    step();
    step();
    check_output("mid_shift busy", uio_out, 8'h04);
    check_output("mid_shift old", uo_out, 8'h0D);
    #2;
    rst_n = 1'b0;
    #1;
    model_uo = 8'h00;
    check_output("async reset uo_out", uo_out, 8'h00);
    check_output("async reset uio_out", uio_out, 8'h00);
    check_output("async reset uio_oe", uio_oe, 8'hFC);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_output("post reset idle", uio_out, 8'h00);
    check_output("post reset uo_out", uo_out, 8'h00);

    // ena low for 3 cycles mid-SHIFT delays the result by exactly 3 cycles.
    ui_in  = {4'd2, 4'd5};
    uio_in = 8'h01;
    step();
    uio_in = 8'h00;
    step();
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      uio_in = 8'($urandom);
      step();
      check_output("frozen busy", uio_out, 8'h04);
      check_output("frozen uo_out", uo_out, 8'h00);
    end
    uio_in = 8'h00;
    ena    = 1'b1;
    step();
    step();
    check_output("ena resume busy", uio_out, 8'h04);
    step();
    model_uo = 8'h1D;
    check_output("ena result", uo_out, model_uo);
    check_output("ena done", uio_out, 8'h08);
    wait_hold("ena");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
